// File: rtl/fbcpu_pkg.sv
// FB-CPU shared definitions: opcodes, FSM states, instruction fields.
// Build option: FBCPU_MUL_EN makes opcode E a memory-operand MUL.
package fbcpu_pkg;

  localparam int OP_W = 4;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JN  = 4'hB;
  localparam logic [3:0] OP_SHL = 4'hC;
  localparam logic [3:0] OP_SHR = 4'hD;
  localparam logic [3:0] OP_MUL = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_FWAIT,
    S_DECODE,
    S_OPADDR,
    S_OPWAIT,
    S_EXEC,
    S_STORE,
    S_HALT
  } state_t;

  function automatic logic isMemOp(input logic [3:0] op);
    logic m;
    m = op inside {OP_LDA, OP_ADD, OP_SUB,
                   OP_AND, OP_OR, OP_XOR};
`ifdef FBCPU_MUL_EN
    m = m | (op == OP_MUL);
`endif
    return m;
  endfunction

endpackage

// File: rtl/fbcpu_alu.sv
// FB-CPU accumulator ALU, purely combinational.
// Build option: FBCPU_MUL_EN enables the multiply path.
module fbcpu_alu
  import fbcpu_pkg::*;
#(
  parameter int DATA_WIDTH = 10
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0] operand,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  isZero,
  output logic                  isNeg
);

  always_comb begin
    result = acc;
    case (op)
      OP_LDA, OP_LDI: result = operand;
      OP_ADD: result = acc + operand;
      OP_SUB: result = acc - operand;
      OP_AND: result = acc & operand;
      OP_OR:  result = acc | operand;
      OP_XOR: result = acc ^ operand;
      OP_NOT: result = ~acc;
      OP_SHL: result = acc << 1;
      OP_SHR: result = acc >> 1;
`ifdef FBCPU_MUL_EN
      OP_MUL: result = acc * operand;
`endif
      default: result = acc;
    endcase
  end

  assign isZero = (acc == '0);
  assign isNeg  = acc[DATA_WIDTH-1];

endmodule

// File: rtl/fbcpu.sv
// FB-CPU multi-cycle accumulator core driving one sync RAM.
// Build option: FBCPU_MUL_EN (opcode E = MUL, else NOP).
module fbcpu
  import fbcpu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [DATA_WIDTH-1:0]    MDRIn,
  output logic                     RAMWr,
  output logic [ADDRESS_WIDTH-1:0] MAR,
  input  logic [DATA_WIDTH-1:0]    MDROut,
  output logic [ADDRESS_WIDTH-1:0] PC
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;

  state_t state, nextState;

  logic [DW-1:0] ir, acc;
  logic [DW-1:0] irD, accD, mdrD;
  logic [AW-1:0] marD, pcD;
  logic          wrD;

  logic [OP_W-1:0] op, decOp;
  logic [AW-1:0]   opa;
  logic [DW-1:0]   operand, aluRes;
  logic            isZero, isNeg, takeJump;

  assign op    = ir[DW-1 -: OP_W];
  assign decOp = MDROut[DW-1 -: OP_W];
  assign opa   = ir[AW-1:0];

  assign operand = isMemOp(op) ? MDROut
                 : {{(DW-AW){1'b0}}, opa};

  fbcpu_alu #(.DATA_WIDTH(DW)) uAlu (
    .op      (op),
    .acc     (acc),
    .operand (operand),
    .result  (aluRes),
    .isZero  (isZero),
    .isNeg   (isNeg)
  );

  assign takeJump = (op == OP_JMP)
                  | ((op == OP_JZ) & isZero)
                  | ((op == OP_JN) & isNeg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      S_FETCH:  nextState = S_FWAIT;
      S_FWAIT:  nextState = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          isMemOp(decOp):    nextState = S_OPADDR;
          (decOp == OP_STA): nextState = S_STORE;
          default:           nextState = S_EXEC;
        endcase
      end
      S_OPADDR: nextState = S_OPWAIT;
      S_OPWAIT: nextState = S_EXEC;
      S_EXEC:   nextState = (op == OP_HLT) ? S_HALT
                                           : S_FETCH;
      S_STORE:  nextState = S_FETCH;
      S_HALT:   nextState = S_HALT;
      default:  nextState = S_FETCH;
    endcase
  end

  always_comb begin
    marD = MAR;
    pcD  = PC;
    irD  = ir;
    accD = acc;
    mdrD = MDRIn;
    wrD  = 1'b0;
    unique case (state)
      S_FETCH:  marD = PC;
      S_DECODE: begin
        irD = MDROut;
        pcD = PC + 1'b1;
      end
      S_OPADDR: marD = opa;
      S_STORE: begin
        marD = opa;
        mdrD = acc;
        wrD  = 1'b1;
      end
      S_EXEC: begin
        if (takeJump) pcD  = opa;
        else          accD = aluRes;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MAR   <= '0;
      PC    <= '0;
      ir    <= '0;
      acc   <= '0;
      MDRIn <= '0;
      RAMWr <= 1'b0;
    end else begin
      MAR   <= marD;
      PC    <= pcD;
      ir    <= irD;
      acc   <= accD;
      MDRIn <= mdrD;
      RAMWr <= wrD;
    end
  end

endmodule

// File: tb/tb_fbcpu.sv
// FB-CPU bench: behavioural RAM plus an instruction-level
// reference interpreter; directed and random programs.
module tb_fbcpu;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] MDRIn, MDROut;
  logic       RAMWr;
  logic [5:0] MAR, PC;

  always #5 clk = ~clk;

  logic [9:0] mem [64];
  logic       ldWe   = 1'b0;
  logic [5:0] ldAddr = '0;
  logic [9:0] ldData = '0;

  always @(posedge clk) begin
    if (ldWe)       mem[ldAddr] <= ldData;
    else if (RAMWr) mem[MAR]    <= MDRIn;
    MDROut <= (RAMWr && !ldWe) ? MDRIn : mem[MAR];
  end

  fbcpu dut (
    .clk    (clk),
    .rst    (rst),
    .MDRIn  (MDRIn),
    .RAMWr  (RAMWr),
    .MAR    (MAR),
    .MDROut (MDROut),
    .PC     (PC)
  );

  int tests = 0;
  int fails = 0;

  logic [9:0] img  [64];
  logic [9:0] expm [64];
  logic [5:0] expPc;
  int expFirst, expCyc;
  int firstDut, cyc;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ins(input int op,
                                     input int a);
    return {op[3:0], a[5:0]};
  endfunction

  task automatic clearImg();
    for (int i = 0; i < 64; i++) img[i] = '0;
  endtask

  task automatic loadImg();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ldWe   = 1'b1;
      ldAddr = 6'(i);
      ldData = img[i];
      @(posedge clk);
      #1;
    end
    ldWe = 1'b0;
  endtask

  // ISA interpreter: one loop pass per instruction.
  task automatic modelRun();
    logic [9:0] acc, m, ir;
    logic [5:0] pc, a;
    logic [3:0] op;
    bit done, memOp;
    for (int i = 0; i < 64; i++) expm[i] = img[i];
    pc = '0; acc = '0; done = 0;
    expCyc = 0; expFirst = -1;
    for (int s = 0; s < 5000 && !done; s++) begin
      ir = expm[pc];
      op = ir[9:6];
      a  = ir[5:0];
      m  = expm[a];
      pc = pc + 6'd1;
      memOp = (op <= 4'd6) && (op != 4'd1);
      case (op)
        4'd0:  acc = m;
        4'd1: begin
          if (expFirst < 0) expFirst = expCyc + 4;
          expm[a] = acc;
        end
        4'd2:  acc = acc + m;
        4'd3:  acc = acc - m;
        4'd4:  acc = acc & m;
        4'd5:  acc = acc | m;
        4'd6:  acc = acc ^ m;
        4'd7:  acc = ~acc;
        4'd8:  acc = {4'd0, a};
        4'd9:  pc = a;
        4'd10: if (acc == 0) pc = a;
        4'd11: if (acc >= 10'd512) pc = a;
        4'd12: acc = 10'(acc * 2);
        4'd13: acc = 10'(acc / 2);
        4'd14: begin
`ifdef FBCPU_MUL_EN
          acc   = acc * m;
          memOp = 1;
`endif
        end
        default: done = 1;
      endcase
      expCyc += memOp ? 6 : 4;
    end
    expPc = pc;
  endtask

  task automatic startRun();
    firstDut = -1;
    cyc      = 0;
    rst      = 1'b1;
  endtask

  task automatic runDut(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (RAMWr === 1'b1 && firstDut < 0)
        firstDut = cyc;
    end
  endtask

  task automatic checkResult(input string tag);
    int nMis;
    nMis = 0;
    for (int i = 0; i < 64; i++)
      if (mem[i] !== expm[i]) nMis++;
    check({tag, ".ram"}, nMis, 0);
    check({tag, ".pc"}, PC, expPc);
    check({tag, ".first"}, firstDut, expFirst);
  endtask

  task automatic addProg();
    clearImg();
    img[0]  = ins(0, 50);
    img[1]  = ins(2, 51);
    img[2]  = ins(1, 52);
    img[3]  = ins(15, 0);
    img[50] = 10'd5;
    img[51] = 10'd10;
  endtask

  initial begin
    bit found;
    int op, a;

    // reset and first fetch
    addProg();
    loadImg();
    check("rst.pc", PC, 0);
    check("rst.mar", MAR, 0);
    check("rst.wr", RAMWr, 0);
    check("rst.mdr", MDRIn, 0);
    modelRun();
    startRun();
    runDut(1);
    check("rel.mar", MAR, 0);
    runDut(2);
    check("rel.pc", PC, 1);
    runDut(1);
    check("rel.opaddr", MAR, 50);
    runDut(9996);
    checkResult("add");
    check("add.m52", mem[52], 15);
    check("add.halt", PC, 4);
    check("add.cyc", firstDut, 16);

    // counted loop
    clearImg();
    img[0]  = ins(0, 52);
    img[1]  = ins(2, 55);
    img[2]  = ins(1, 52);
    img[3]  = ins(0, 53);
    img[4]  = ins(3, 54);
    img[5]  = ins(1, 53);
    img[6]  = ins(10, 8);
    img[7]  = ins(9, 0);
    img[8]  = ins(15, 0);
    img[53] = 10'd5;
    img[54] = 10'd1;
    img[55] = 10'd10;
    loadImg();
    modelRun();
    startRun();
    runDut(10000);
    checkResult("loop");
    check("loop.m52", mem[52], 50);

    // branch paths
    clearImg();
    img[0]  = ins(8, 0);
    img[1]  = ins(10, 3);
    img[2]  = ins(15, 0);
    img[3]  = ins(8, 6'h11);
    img[4]  = ins(1, 56);
    img[5]  = ins(0, 60);
    img[6]  = ins(11, 8);
    img[7]  = ins(15, 0);
    img[8]  = ins(8, 6'h22);
    img[9]  = ins(1, 57);
    img[10] = ins(8, 1);
    img[11] = ins(10, 14);
    img[12] = ins(8, 6'h33);
    img[13] = ins(1, 52);
    img[14] = ins(15, 0);
    img[60] = 10'h200;
    loadImg();
    modelRun();
    startRun();
    runDut(10000);
    checkResult("br");
    check("br.jz", mem[56], 10'h11);
    check("br.jn", mem[57], 10'h22);
    check("br.fall", mem[52], 10'h33);

    // MUL or NOP on opcode E
    clearImg();
    img[0]  = ins(8, 5);
    img[1]  = ins(14, 51);
    img[2]  = ins(1, 52);
    img[3]  = ins(15, 0);
    img[51] = 10'd10;
    img[52] = 10'd5;
    loadImg();
    modelRun();
    startRun();
    runDut(10000);
    checkResult("mul");
`ifdef FBCPU_MUL_EN
    check("mul.m52", mem[52], 50);
`else
    check("mul.m52", mem[52], 5);
`endif

    // random forward-only programs
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 64; i++)
        img[i] = 10'($urandom_range(0, 1023));
      for (int i = 20; i < 32; i++)
        img[i] = ins(15, 0);
      for (int i = 0; i < 20; i++) begin
        op = int'($urandom_range(0, 14));
        if (op >= 9 && op <= 11)
          a = int'($urandom_range(i + 1, 20));
        else if (op <= 6 || op == 14)
          a = int'($urandom_range(32, 63));
        else
          a = int'($urandom_range(0, 63));
        img[i] = ins(op, a);
      end
      loadImg();
      modelRun();
      startRun();
      runDut(expCyc + 40);
      checkResult($sformatf("rnd%0d", t));
    end

    // reset while a store is being written
    addProg();
    loadImg();
    startRun();
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(posedge clk);
      #1;
      if (RAMWr === 1'b1) found = 1;
    end
    check("mid.seen", found, 1);
    #2 rst = 1'b0;
    #1;
    check("mid.wr", RAMWr, 0);
    check("mid.pc", PC, 0);
    check("mid.nowrite", mem[52], 0);
    loadImg();
    modelRun();
    startRun();
    runDut(10000);
    checkResult("rerun");
    check("rerun.m52", mem[52], 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
